// File: rtl/adc_delay_ctrl.sv
// IODELAY tap sequencer: on each change of the delay register, reset the masked
// lanes' IODELAYs and then step them up to the requested tap with paced CE pulses.
module adc_delay_ctrl #(
  parameter int unsigned C_NUM_LANES  = 8,
  parameter int unsigned C_TAP_WIDTH  = 5,
  parameter int unsigned C_GAP_CYCLES = 2
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic [31:0]            user_data_in,
  output logic [C_NUM_LANES-1:0] dly_rst,
  output logic [C_NUM_LANES-1:0] dly_ce,
  output logic                   dly_inc,
  output logic                   busy,
  output logic [C_TAP_WIDTH-1:0] applied_tap,
  output logic [15:0]            apply_count
);

  localparam int unsigned SW = C_TAP_WIDTH + 1;
  localparam int unsigned GW = (C_GAP_CYCLES > 1) ? $clog2(C_GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RST    = 3'd2,
    SETTLE = 3'd3,
    STEP   = 3'd4,
    GAP    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_last_val;
  logic                   r_pending;
  logic [C_NUM_LANES-1:0] r_mask;
  logic [C_TAP_WIDTH-1:0] r_target;
  logic [SW-1:0]          r_step_cnt;
  logic                   r_settle_cnt;
  logic [GW-1:0]          r_gap_cnt;
  logic                   w_change;
  logic                   w_gap_last;
  logic                   w_more_steps;

  logic [C_NUM_LANES-1:0] r_dly_rst;
  logic [C_NUM_LANES-1:0] r_dly_ce;
  logic                   r_dly_inc;
  logic                   r_busy;
  logic [C_TAP_WIDTH-1:0] r_applied_tap;
  logic [15:0]            r_apply_count;

  assign w_change     = (user_data_in != r_last_val);
  assign w_gap_last   = (r_gap_cnt == GW'(C_GAP_CYCLES - 1));
  // Step counter is one bit wider so a full-scale target never wraps it.
  assign w_more_steps = (r_step_cnt < {1'b0, r_target});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_change) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = (r_last_val[C_NUM_LANES-1:0] == '0) ? DONE : RST;
      RST:     w_state_nxt = SETTLE;
      SETTLE:  if (r_settle_cnt) w_state_nxt = (r_target != '0) ? STEP : DONE;
      STEP:    w_state_nxt = GAP;
      GAP:     if (w_gap_last) w_state_nxt = w_more_steps ? STEP : DONE;
      DONE:    w_state_nxt = (r_pending || w_change) ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state    <= IDLE;
      r_last_val <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_val <= user_data_in;
      // A change seen during LOAD must survive the clear, hence set-over-clear.
      if ((r_state != IDLE) && w_change)
        r_pending <= 1'b1;
      else if (r_state == LOAD)
        r_pending <= 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_mask       <= '0;
      r_target     <= '0;
      r_step_cnt   <= '0;
      r_settle_cnt <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_mask     <= r_last_val[C_NUM_LANES-1:0];
          r_target   <= r_last_val[8 +: C_TAP_WIDTH];
          r_step_cnt <= '0;
        end
        RST:    r_settle_cnt <= 1'b0;
        SETTLE: r_settle_cnt <= 1'b1;
        STEP: begin
          r_step_cnt <= r_step_cnt + SW'(1);
          r_gap_cnt  <= '0;
        end
        GAP:    r_gap_cnt <= r_gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  // Strobes are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_dly_rst     <= '0;
      r_dly_ce      <= '0;
      r_dly_inc     <= 1'b0;
      r_busy        <= 1'b0;
      r_applied_tap <= '0;
      r_apply_count <= '0;
    end else begin
      r_dly_rst <= (r_state == RST)  ? r_mask : '0;
      r_dly_ce  <= (r_state == STEP) ? r_mask : '0;
      r_dly_inc <= (r_state == STEP);
      r_busy    <= (r_state != IDLE);
      if (r_state == DONE) begin
        r_applied_tap <= r_target;
        r_apply_count <= r_apply_count + 16'd1;
      end
    end
  end

  assign dly_rst     = r_dly_rst;
  assign dly_ce      = r_dly_ce;
  assign dly_inc     = r_dly_inc;
  assign busy        = r_busy;
  assign applied_tap = r_applied_tap;
  assign apply_count = r_apply_count;

endmodule

// File: doc/adc_delay_ctrl.md
ADC_DELAY_CTRL -- requirements
Module: adc_delay_ctrl

Interface
REQ-001 SHALL provide parameter C_NUM_LANES, default 8, number of ADC data lanes with IODELAY.
REQ-002 SHALL provide parameter C_TAP_WIDTH, default 5, width of the IODELAY tap value (0..31).
REQ-003 SHALL provide parameter C_GAP_CYCLES, default 2, number of idle cycles between successive tap steps (minimum 1).
REQ-004 user_clk  input  1  sole clock; the same domain as user_data_out of the adc0_delay software register.
REQ-005 user_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 user_data_in  input  32  delay register value: [C_NUM_LANES-1:0] lane mask, [8+C_TAP_WIDTH-1:8] target tap, other bits ignored.
REQ-007 dly_rst  output  C_NUM_LANES  per-lane IODELAY reset pulse (tap to 0).
REQ-008 dly_ce  output  C_NUM_LANES  per-lane IODELAY count-enable pulse.
REQ-009 dly_inc  output  1  IODELAY increment direction.
REQ-010 busy  output  1  sequence in progress.
REQ-011 applied_tap  output  C_TAP_WIDTH  last tap value fully applied.
REQ-012 apply_count  output  16  number of completed sequences, wraps at 65535->0.

Function
REQ-013 SHALL register user_data_in every cycle into last_val and flag a change when user_data_in != last_val.
REQ-014 FSM states SHALL be IDLE, LOAD, RST, SETTLE, STEP, GAP, DONE.
REQ-015 IDLE: on change flag, SHALL go to LOAD; otherwise remain, busy=0.
REQ-016 LOAD (1 cycle): SHALL capture mask and target from last_val, clear pending, assert busy; if mask==0 go to DONE, else RST.
REQ-017 RST (1 cycle): dly_rst=mask, dly_ce=0; next SETTLE.
REQ-018 SETTLE: SHALL hold all strobes low for exactly 2 cycles, then STEP if target>0, else DONE.
REQ-019 STEP (1 cycle): dly_ce=mask, dly_inc=1, step counter increments; next GAP.
REQ-020 GAP: all strobes low for C_GAP_CYCLES cycles; then STEP if step counter<target, else DONE.
REQ-021 DONE (1 cycle): applied_tap=target, apply_count+=1; if pending then LOAD else IDLE.
REQ-022 Latency: first dly_rst pulse SHALL occur exactly 3 cycles after the cycle in which the new value first appears on user_data_in.
REQ-023 Exactly target dly_ce pulses per sequence; each strobe high exactly 1 cycle; dly_rst and dly_ce never high in the same cycle.
REQ-024 Change detected in any state other than IDLE SHALL set pending; multiple changes collapse to one rerun using the newest value at LOAD.
REQ-025 Change arriving in the same cycle as DONE SHALL set pending and cause rerun.
REQ-026 Lanes with mask bit 0 SHALL never see dly_rst or dly_ce.
REQ-027 dly_inc SHALL be 1 whenever dly_ce is nonzero, 0 otherwise.
REQ-028 busy SHALL be 1 in all states except IDLE.
REQ-029 target = 2^C_TAP_WIDTH-1 SHALL produce exactly 31 steps (default) with no counter overflow.

Reset
REQ-030 user_rst_n low SHALL immediately force: state IDLE, dly_rst=0, dly_ce=0, dly_inc=0, busy=0, applied_tap=0, apply_count=0, pending=0, last_val=0.
REQ-031 Reset mid-sequence SHALL abandon the sequence with no further pulses; after release a nonzero user_data_in is treated as a change and runs a full sequence.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 Reset, then user_data_in=0x00000A0F -> LOAD, dly_rst=0x0F one cycle, 10 dly_ce=0x0F pulses spaced 3 cycles, applied_tap=10, apply_count=1, busy low.
REQ-034 user_data_in=0x00000003 (target 0, lanes 0-1) -> dly_rst=0x03 only, no dly_ce, applied_tap=0.
REQ-035 Mask=0, user_data_in=0x00001F00 -> no strobes, busy high for 2 cycles, applied_tap=31, apply_count increments.
REQ-036 During 0x000014FF sequence, write 0x000005FF then 0x000007FF -> first run completes (20 pulses), single rerun with 7 pulses, apply_count +2.
REQ-037 Assert user_rst_n low after 4th dly_ce of 0x00001001 -> all outputs 0 immediately, no pulses while low; release -> full rerun with 16 pulses on lane 0.
REQ-038 Value 0x00001FFF -> 31 dly_ce=0xFF pulses, applied_tap=31; rewriting identical value -> no new sequence.
